// File: rtl/seq_div_pkg.sv
// -----------------------------------------------------------------------------
// seq_div_pkg
//   Shared definitions for the sequential restoring divider:
//     - default dividend/quotient width (N_W_DEF) and divisor/remainder
//       width (D_W_DEF)
//     - iteration counter width helper and its default value
//     - controller state encoding (IDLE / RUN / DONE)
// -----------------------------------------------------------------------------
package seq_div_pkg;

    localparam int N_W_DEF = 8;
    localparam int D_W_DEF = 4;

    // The counter must be able to hold the value N_W itself, hence N_W+1.
    function automatic int cnt_width(input int n_w);
        return $clog2(n_w + 1);
    endfunction

    localparam int CNT_W_DEF = $clog2(N_W_DEF + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage : seq_div_pkg

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step
//   One purely combinational restoring-division iteration.
//   Ports:
//     i_r  [D_W:0]   current partial remainder R
//     i_q  [N_W-1:0] dividend/quotient shift register Q
//     i_d  [D_W-1:0] divisor D
//     o_r  [D_W:0]   partial remainder after this iteration
//     o_q  [N_W-1:0] Q shifted left with the new quotient bit in its LSB
// -----------------------------------------------------------------------------
module div_step
    import seq_div_pkg::*;
#(
    parameter int N_W = N_W_DEF,
    parameter int D_W = D_W_DEF
) (
    input  logic [D_W:0]   i_r,
    input  logic [N_W-1:0] i_q,
    input  logic [D_W-1:0] i_d,
    output logic [D_W:0]   o_r,
    output logic [N_W-1:0] o_q
);

    logic [D_W:0] w_shift;
    logic [D_W:0] w_d_ext;
    logic         w_ge;

    // Bring the next dividend bit into the bottom of the partial remainder.
    // R is always < D after a step, so dropping R[D_W] loses nothing.
    assign w_shift = {i_r[D_W-1:0], i_q[N_W-1]};
    assign w_d_ext = {1'b0, i_d};
    assign w_ge    = (w_shift >= w_d_ext);

    // Restore-by-not-subtracting: only commit the difference when it fits.
    assign o_r = w_ge ? (w_shift - w_d_ext) : w_shift;
    assign o_q = {i_q[N_W-2:0], w_ge};

endmodule : div_step

// File: rtl/tt_um_seq_divider.sv
// -----------------------------------------------------------------------------
// tt_um_seq_divider
//   Tiny Tapeout pin wrapper around seq_divider_core.
//   Ports:
//     ui_in[7:0]    dividend
//     uio_in[3:0]   divisor
//     uio_in[4]     start
//     uo_out[7:0]   quotient
//     uio_out[7:4]  remainder (uio_out[3:0] driven 0)
//     uio_oe[7:0]   8'hF0: upper nibble output, lower nibble input
//     ena, clk      harness enable and clock
//     rst_n         active-low reset, inverted into the core's rst
// -----------------------------------------------------------------------------
module tt_um_seq_divider (
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena,
    input  logic       clk,
    input  logic       rst_n
);

    logic [7:0] w_quotient;
    logic [3:0] w_remainder;
    logic       w_busy;
    logic       w_done;
    logic       w_dbz;
    logic       w_unused;

    seq_divider_core #(
        .N_W (8),
        .D_W (4)
    ) u_core (
        .clk         (clk),
        .rst         (~rst_n),
        .start       (uio_in[4]),
        .dividend    (ui_in),
        .divisor     (uio_in[3:0]),
        .busy        (w_busy),
        .done        (w_done),
        .quotient    (w_quotient),
        .remainder   (w_remainder),
        .div_by_zero (w_dbz)
    );

    assign uo_out  = w_quotient;
    assign uio_out = {w_remainder, 4'b0000};
    assign uio_oe  = 8'hF0;

    // Status flags have no pins on this wrapper; gather them with the unused
    // inputs so the intent is explicit.
    assign w_unused = &{1'b0, ena, uio_in[7:5], w_busy, w_done, w_dbz};

endmodule : tt_um_seq_divider

// File: rtl/seq_divider_core.sv
// -----------------------------------------------------------------------------
// seq_divider_core
//   Unsigned sequential restoring divider, one quotient bit per clock.
//   Ports:
//     clk          rising-edge clock
//     rst          synchronous, active-high reset
//     start        request, only honoured while idle
//     dividend     [N_W-1:0] unsigned, sampled with start
//     divisor      [D_W-1:0] unsigned, sampled with start
//     busy         high while an operation is in flight (RUN or DONE)
//     done         one-cycle pulse when results become valid
//     quotient     [N_W-1:0] result, held until the next accepted start
//     remainder    [D_W-1:0] result, held until the next accepted start
//     div_by_zero  set when the accepted divisor was zero
//   All outputs come straight from flops.
// -----------------------------------------------------------------------------
module seq_divider_core
    import seq_div_pkg::*;
#(
    parameter int N_W = N_W_DEF,
    parameter int D_W = D_W_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N_W-1:0] dividend,
    input  logic [D_W-1:0] divisor,
    output logic           busy,
    output logic           done,
    output logic [N_W-1:0] quotient,
    output logic [D_W-1:0] remainder,
    output logic           div_by_zero
);

    localparam int CNT_W = cnt_width(N_W);

    // ---------------------------------------------------------------- state
    state_t         r_state;
    state_t         w_state_next;
    logic           r_busy;
    logic           r_done;

    // ------------------------------------------------------------- datapath
    logic [N_W-1:0] r_q;
    logic [D_W:0]   r_r;
    logic [D_W-1:0] r_d;
    logic [CNT_W-1:0] r_cnt;
    logic [N_W-1:0] r_quotient;
    logic [D_W-1:0] r_remainder;
    logic           r_dbz;

    logic [N_W-1:0] w_q_next;
    logic [D_W:0]   w_r_next;
    logic           w_accept;
    logic           w_last;
    logic           w_div_zero;

    assign w_accept   = (r_state == ST_IDLE) && start;
    assign w_div_zero = (divisor == '0);
    // The final iteration is the one that takes the counter from 1 to 0.
    assign w_last     = (r_state == ST_RUN) && (r_cnt == CNT_W'(1));

    div_step #(
        .N_W (N_W),
        .D_W (D_W)
    ) u_div_step (
        .i_r (r_r),
        .i_q (r_q),
        .i_d (r_d),
        .o_r (w_r_next),
        .o_q (w_q_next)
    );

    // ------------------------------------------------------ next-state logic
    // NOTE: give every always_comb output a default before any branch so that
    // no path leaves it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = w_div_zero ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // --------------------------------------------------------- state register
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge value of its sources regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            // busy/done are registered copies of the next state so they switch
            // together with the state and stay glitch-free at the pins.
            r_busy  <= (w_state_next != ST_IDLE);
            r_done  <= (w_state_next == ST_DONE);
        end
    end

    // --------------------------------------------------------------- datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q         <= '0;
            r_r         <= '0;
            r_d         <= '0;
            r_cnt       <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
        end else if (w_accept) begin
            r_q   <= dividend;
            r_d   <= divisor;
            r_r   <= '0;
            r_cnt <= CNT_W'(N_W);
            // A zero divisor skips RUN entirely, so its result is loaded now
            // and is already valid in the DONE cycle that follows.
            if (w_div_zero) begin
                r_quotient  <= '1;
                r_remainder <= '0;
                r_dbz       <= 1'b1;
            end else begin
                r_quotient  <= '0;
                r_remainder <= '0;
                r_dbz       <= 1'b0;
            end
        end else if (r_state == ST_RUN) begin
            r_r   <= w_r_next;
            r_q   <= w_q_next;
            r_cnt <= r_cnt - CNT_W'(1);
            if (w_last) begin
                r_quotient  <= w_q_next;
                r_remainder <= w_r_next[D_W-1:0];
            end
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_dbz;

endmodule : seq_divider_core

// File: tb/tb_seq_divider_core.sv
module tb_seq_divider_core;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;

    int n_cmp = 0;
    int n_mis = 0;

    seq_divider_core #(.N_W(8), .D_W(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one request (start high for one edge) and wait for done.
    // lat: cycles from the start cycle to the done cycle (30 = timed out).
    // busy_cyc: cycles with busy high up to and including the done cycle.
    // done_tail: done one cycle after the observed pulse.
    task automatic run_div(input logic [7:0] a, input logic [3:0] b,
                           output int lat, output int busy_cyc,
                           output logic done_tail);
        @(negedge clk);
        start = 1'b1; dividend = a; divisor = b;
        @(negedge clk);
        start = 1'b0; dividend = 8'hA5; divisor = 4'hA;
        lat = 1; busy_cyc = 0;
        while (done !== 1'b1 && lat < 30) begin
            if (busy === 1'b1) busy_cyc++;
            @(negedge clk);
            lat++;
        end
        if (busy === 1'b1) busy_cyc++;
        @(negedge clk);
        done_tail = done;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({busy, done, quotient, remainder, div_by_zero} !== 15'd0) begin
            n_mis++;
            $display("FAIL reset_outputs: got busy=%b done=%b q=%0d r=%0d z=%b want all 0",
                     busy, done, quotient, remainder, div_by_zero);
        end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_mis++;
            $display("FAIL reset_idle_busy: got %b want 0", busy);
        end
    endtask

    task automatic test_timing_200_7();
        int lat, bc; logic tail;
        run_div(8'd200, 4'd7, lat, bc, tail);
        n_cmp++;
        if (lat != 9) begin n_mis++; $display("FAIL t200_latency: got %0d want 9", lat); end
        n_cmp++;
        if (bc != 9) begin n_mis++; $display("FAIL t200_busy_cycles: got %0d want 9", bc); end
        n_cmp++;
        if (tail !== 1'b0) begin n_mis++; $display("FAIL t200_done_width: got done=%b want 0", tail); end
        n_cmp++;
        if ({quotient, remainder, div_by_zero} !== {8'd28, 4'd4, 1'b0}) begin
            n_mis++;
            $display("FAIL t200_result: got q=%0d r=%0d z=%b want q=28 r=4 z=0",
                     quotient, remainder, div_by_zero);
        end
        n_cmp++;
        if (busy !== 1'b0) begin n_mis++; $display("FAIL t200_idle_after: got busy=%b want 0", busy); end
    endtask

    task automatic test_vectors();
        logic [7:0] va [6] = '{8'd255, 8'd5, 8'd0,  8'd225, 8'd13, 8'd127};
        logic [3:0] vb [6] = '{4'd1,   4'd9, 4'd15, 4'd15,  4'd13, 4'd4};
        logic [7:0] vq [6] = '{8'd255, 8'd0, 8'd0,  8'd15,  8'd1,  8'd31};
        logic [3:0] vr [6] = '{4'd0,   4'd5, 4'd0,  4'd0,   4'd0,  4'd3};
        int lat, bc; logic tail;
        for (int i = 0; i < 6; i++) begin
            run_div(va[i], vb[i], lat, bc, tail);
            n_cmp++;
            if (lat != 9) begin n_mis++; $display("FAIL vec%0d_latency: got %0d want 9", i, lat); end
            n_cmp++;
            if ({quotient, remainder, div_by_zero} !== {vq[i], vr[i], 1'b0}) begin
                n_mis++;
                $display("FAIL vec%0d_result %0d/%0d: got q=%0d r=%0d z=%b want q=%0d r=%0d z=0",
                         i, va[i], vb[i], quotient, remainder, div_by_zero, vq[i], vr[i]);
            end
            // Results must stay put while idle.
            repeat (2) @(negedge clk);
            n_cmp++;
            if ({quotient, remainder} !== {vq[i], vr[i]}) begin
                n_mis++;
                $display("FAIL vec%0d_hold: got q=%0d r=%0d want q=%0d r=%0d",
                         i, quotient, remainder, vq[i], vr[i]);
            end
        end
    endtask

    task automatic test_div_by_zero();
        int lat, bc; logic tail;
        run_div(8'd100, 4'd0, lat, bc, tail);
        n_cmp++;
        if (lat != 1) begin n_mis++; $display("FAIL dbz_latency: got %0d want 1", lat); end
        n_cmp++;
        if (bc != 1) begin n_mis++; $display("FAIL dbz_busy_cycles: got %0d want 1", bc); end
        n_cmp++;
        if (tail !== 1'b0) begin n_mis++; $display("FAIL dbz_done_width: got done=%b want 0", tail); end
        n_cmp++;
        if ({quotient, remainder, div_by_zero} !== {8'd255, 4'd0, 1'b1}) begin
            n_mis++;
            $display("FAIL dbz_result: got q=%0d r=%0d z=%b want q=255 r=0 z=1",
                     quotient, remainder, div_by_zero);
        end
        // The flag must clear on the next accepted (normal) start.
        run_div(8'd9, 4'd3, lat, bc, tail);
        n_cmp++;
        if ({quotient, remainder, div_by_zero} !== {8'd3, 4'd0, 1'b0}) begin
            n_mis++;
            $display("FAIL dbz_clear: got q=%0d r=%0d z=%b want q=3 r=0 z=0",
                     quotient, remainder, div_by_zero);
        end
    endtask

    task automatic test_start_during_run();
        int lat;
        @(negedge clk);
        start = 1'b1; dividend = 8'd50; divisor = 4'd3;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; dividend = 8'd99; divisor = 4'd2;
        @(negedge clk);
        start = 1'b0; dividend = 8'd0; divisor = 4'd0;
        lat = 3;
        while (done !== 1'b1 && lat < 30) begin @(negedge clk); lat++; end
        n_cmp++;
        if (lat != 9) begin n_mis++; $display("FAIL srun_latency: got %0d want 9", lat); end
        n_cmp++;
        if ({quotient, remainder, div_by_zero} !== {8'd16, 4'd2, 1'b0}) begin
            n_mis++;
            $display("FAIL srun_result: got q=%0d r=%0d z=%b want q=16 r=2 z=0",
                     quotient, remainder, div_by_zero);
        end
        repeat (2) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin n_mis++; $display("FAIL srun_no_queue: got busy=%b want 0", busy); end
    endtask

    task automatic test_back_to_back();
        int lat;
        @(negedge clk);
        start = 1'b1; dividend = 8'd50; divisor = 4'd3;
        lat = 0;
        do begin @(negedge clk); lat++; end while (done !== 1'b1 && lat < 30);
        n_cmp++;
        if ({quotient, remainder} !== {8'd16, 4'd2}) begin
            n_mis++;
            $display("FAIL b2b_first: got q=%0d r=%0d want q=16 r=2", quotient, remainder);
        end
        @(negedge clk);
        n_cmp++;
        if ({busy, done} !== 2'b00) begin
            n_mis++;
            $display("FAIL b2b_gap: got busy=%b done=%b want 0 0", busy, done);
        end
        dividend = 8'd99; divisor = 4'd2;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1) begin n_mis++; $display("FAIL b2b_restart: got busy=%b want 1", busy); end
        start = 1'b0;
        lat = 1;
        while (done !== 1'b1 && lat < 30) begin @(negedge clk); lat++; end
        n_cmp++;
        if (lat != 9) begin n_mis++; $display("FAIL b2b_second_latency: got %0d want 9", lat); end
        n_cmp++;
        if ({quotient, remainder} !== {8'd49, 4'd1}) begin
            n_mis++;
            $display("FAIL b2b_second: got q=%0d r=%0d want q=49 r=1", quotient, remainder);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        int lat, bc; logic tail;
        @(negedge clk);
        start = 1'b1; dividend = 8'd200; divisor = 4'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if ({busy, done, quotient, remainder, div_by_zero} !== 15'd0) begin
            n_mis++;
            $display("FAIL midrst_outputs: got busy=%b done=%b q=%0d r=%0d z=%b want all 0",
                     busy, done, quotient, remainder, div_by_zero);
        end
        run_div(8'd77, 4'd5, lat, bc, tail);
        n_cmp++;
        if (lat != 9) begin n_mis++; $display("FAIL midrst_latency: got %0d want 9", lat); end
        n_cmp++;
        if ({quotient, remainder, div_by_zero} !== {8'd15, 4'd2, 1'b0}) begin
            n_mis++;
            $display("FAIL midrst_result: got q=%0d r=%0d z=%b want q=15 r=2 z=0",
                     quotient, remainder, div_by_zero);
        end
    endtask

    task automatic test_sweep();
        int lat, bc; logic tail;
        logic [7:0] eq; logic [3:0] er; logic ez; int want_lat;
        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 16; b++) begin
                run_div(8'(a), 4'(b), lat, bc, tail);
                if (b == 0) begin
                    eq = 8'd255; er = 4'd0; ez = 1'b1; want_lat = 1;
                end else begin
                    eq = 8'(a / b); er = 4'(a % b); ez = 1'b0; want_lat = 9;
                end
                n_cmp++;
                if ({quotient, remainder, div_by_zero} !== {eq, er, ez}) begin
                    n_mis++;
                    $display("FAIL sweep %0d/%0d: got q=%0d r=%0d z=%b want q=%0d r=%0d z=%b",
                             a, b, quotient, remainder, div_by_zero, eq, er, ez);
                end
                n_cmp++;
                if (lat != want_lat || tail !== 1'b0) begin
                    n_mis++;
                    $display("FAIL sweep_timing %0d/%0d: got lat=%0d tail=%b want lat=%0d tail=0",
                             a, b, lat, tail, want_lat);
                end
                if (b != 0) begin
                    n_cmp++;
                    if ((int'(quotient) * b + int'(remainder)) != a || int'(remainder) >= b) begin
                        n_mis++;
                        $display("FAIL sweep_invariant %0d/%0d: got q=%0d r=%0d",
                                 a, b, quotient, remainder);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_timing_200_7();
        test_vectors();
        test_div_by_zero();
        test_start_during_run();
        test_back_to_back();
        test_reset_mid_run();
        test_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule : tb_seq_divider_core

// File: doc/seq_divider_core.md
# seq_divider_core

Unsigned sequential restoring divider: the inverse operation of the team's structural array multiplier. It accepts an 8-bit dividend (product-width) and a 4-bit divisor (operand-width) and returns the quotient and remainder after one iteration per cycle. It sits behind the Tiny Tapeout top wrapper `tt_um_seq_divider`, which maps pins to the core ports and derives `rst` by inverting `rst_n`. It also serves as a round-trip checker for multiplier results.

## Interface
- `N_W`, default 8: dividend and quotient width.
- `D_W`, default 4: divisor and remainder width.

Ports (one clock `clk`; reset `rst` is synchronous, active-high):
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous active-high reset.
- `start`  in  1  request; sampled only in IDLE.
- `dividend`  in  N_W  unsigned; sampled with `start`.
- `divisor`  in  D_W  unsigned; sampled with `start`.
- `busy`  out  1  high whenever state ≠ IDLE.
- `done`  out  1  one-cycle pulse; results valid.
- `quotient`  out  N_W  registered result; held until the next accepted start.
- `remainder`  out  D_W  registered result; held until the next accepted start.
- `div_by_zero`  out  1  registered flag; same lifetime as the results.

## Operation
States: IDLE, RUN, DONE.

- **IDLE.** On `start=1` at an edge:
  - Latch `dividend` into the shift register Q and `divisor` into D.
  - Clear the partial remainder R (D_W+1 bits). Set the counter to N_W.
  - Clear `quotient`, `remainder` and `div_by_zero`.
  - If `divisor==0`, go to DONE. Otherwise go to RUN.
- **RUN.** Each edge performs one step:
  - R' = {R[D_W-1:0], Q[N_W-1]}.
  - If R' ≥ {1'b0,D}: R = R' − D and shift 1 into Q LSB. Else: R = R' and shift 0 into Q LSB.
  - Decrement the counter. At the edge where the counter reaches 0, load `quotient`=Q and `remainder`=R[D_W-1:0], then go to DONE.
- **DONE.** `done=1` for exactly one cycle; the next edge goes to IDLE.
- **Divide by zero.** `quotient`=all ones (255), `remainder`=0, `div_by_zero`=1.
- **Arithmetic.** Fully unsigned. R never exceeds D_W+1 bits. The invariant dividend = quotient·divisor + remainder holds with remainder < divisor.
- **`start` outside IDLE.** Ignored in RUN and DONE, with no queuing. Operand inputs are don't-care outside the accepting edge.
- **Reset.** Effective at any edge, including mid-RUN. State goes to IDLE. `busy`, `done`, `quotient`, `remainder` and `div_by_zero` all go to 0. The in-flight operation is discarded.

## Timing
- Start accepted at edge k. `busy` is high from cycle k+1 through the DONE cycle.
- Normal divide:
  - Iterations occur at edges k+1..k+N_W.
  - `done` is high in the cycle after edge k+N_W, i.e. N_W+1 cycles after the start cycle (9 for defaults).
  - Back to IDLE at edge k+N_W+1.
- Divide by zero: `done` is high in the cycle after edge k (latency 1). `busy` is high for that single cycle.
- Minimum start-to-start spacing: N_W+2 cycles (normal), 2 cycles (divide by zero). A `start` held high continuously is re-accepted on the first IDLE edge.
- Outputs are driven from registers only; no combinational path from inputs to outputs.

## Structure
- Package `seq_div_pkg` holds:
  - the state enum (IDLE/RUN/DONE);
  - default widths N_W/D_W;
  - the counter width localparam $clog2(N_W+1).
- One sub-module, `div_step`: purely combinational, one restoring iteration.
  - Inputs: R, Q, D. Outputs: next R, next Q.
  - The core instantiates it once and registers its outputs each RUN cycle.
- `tt_um_seq_divider` wrapper (separate file) maps:
  - `ui_in`→dividend; `uio_in[3:0]`→divisor; `uio_in[4]`→start.
  - `uo_out`→quotient; `uio_out[7:4]`→remainder.
  - `uio_oe`=8'hF0; `rst`=~rst_n.

## Test plan
- 200 / 7 → quotient 28, remainder 4, `div_by_zero` 0. `done` pulses exactly 9 cycles after the start cycle; `busy` is high for 9 cycles.
- 255 / 1 → 255, 0; 5 / 9 → 0, 5; 0 / 15 → 0, 0; 225 / 15 → 15, 0 (a multiplier-product round trip).
- 100 / 0 → quotient 255, remainder 0, `div_by_zero` 1. `done` in the cycle after start; no RUN cycles.
- `start` with 50/3 re-asserted with 99/2 during RUN → second request ignored, result 16, 2. A start held high then yields back-to-back results with exactly one idle cycle between.
- `rst` asserted at the 4th RUN cycle → next cycle `busy`=0, `done`=0, all outputs 0. A fresh 77/5 afterwards → 15, 2 with normal latency.
- Random sweep of all 256×16 operand pairs against a reference model, checking the quotient/remainder invariant and that `done` is one cycle wide.
